ir_cam_ctrl: RTL and testbench



---
 rtl/ir_cam_ctrl_if.sv | 57 +++++
 rtl/ir_cam_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ir_cam_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ir_cam_ctrl_if.sv
// ---------------------------------------------------------------------------
// ir_cam_ctrl_if
//   Bundles the decoded-key input stream and the camera control outputs of
//   ir_cam_ctrl.
//
//   master : the key source / observer (IR receiver side, or a testbench).
//   slave  : the ir_cam_ctrl block itself.
//
//   Signals
//     key_code    [7:0] decoded key from the IR receiver
//     key_valid         1-cycle strobe, key_code valid when high
//     brightness  [7:0] brightness offset, unsigned, saturating
//     filter_mode [2:0] current filter index
//     freeze            1 = hold current frame
//     capture_req       1-cycle capture pulse
//     busy              high whenever the controller is not idle
//     unknown_key       1-cycle pulse on an unrecognised code
//   With IR_CTRL_STATUS_EN defined, two status signals are added:
//     last_key    [7:0] code applied most recently
//     unknown_cnt [7:0] saturating count of unknown_key pulses
// ---------------------------------------------------------------------------
interface ir_cam_ctrl_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic [7:0] brightness;
  logic [2:0] filter_mode;
  logic       freeze;
  logic       capture_req;
  logic       busy;
  logic       unknown_key;
`ifdef IR_CTRL_STATUS_EN
  logic [7:0] last_key;
  logic [7:0] unknown_cnt;

  modport master (
    output key_code, key_valid,
    input  brightness, filter_mode, freeze, capture_req, busy, unknown_key,
    input  last_key, unknown_cnt
  );

  modport slave (
    input  key_code, key_valid,
    output brightness, filter_mode, freeze, capture_req, busy, unknown_key,
    output last_key, unknown_cnt
  );
`else
  modport master (
    output key_code, key_valid,
    input  brightness, filter_mode, freeze, capture_req, busy, unknown_key
  );

  modport slave (
    input  key_code, key_valid,
    output brightness, filter_mode, freeze, capture_req, busy, unknown_key
  );
`endif
endinterface

// File: rtl/ir_cam_ctrl.sv
// ---------------------------------------------------------------------------
// ir_cam_ctrl
//   Maps decoded IR remote keys onto camera control registers (brightness,
//   filter mode, freeze) and a capture request pulse. After every recognised
//   key a lockout window swallows further key strobes so one physical press
//   issues one command.
//
//   Ports
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    ir_cam_ctrl_if.slave: key_code/key_valid in; brightness,
//            filter_mode, freeze, capture_req, busy, unknown_key out
//
//   Optional feature macro: IR_CTRL_STATUS_EN
//     When defined, bus.last_key (code of the most recent applied key,
//     recognised or not) and bus.unknown_cnt (saturating count of unknown
//     keys) are driven. When undefined that logic does not exist.
//
//   Timing: key_valid sampled at edge N -> updates and pulses visible after
//   edge N+1. A recognised key keeps busy high for 1 + LOCKOUT_CYC cycles,
//   an unrecognised one for 1 cycle.
// ---------------------------------------------------------------------------
module ir_cam_ctrl #(
  parameter logic [7:0] KEY_BRIGHT_UP = 8'h1A,
  parameter logic [7:0] KEY_BRIGHT_DN = 8'h1E,
  parameter logic [7:0] KEY_FILTER    = 8'h12,
  parameter logic [7:0] KEY_FREEZE    = 8'h16,
  parameter logic [7:0] KEY_CAPTURE   = 8'h0D,
  parameter logic [7:0] KEY_RESET     = 8'h0C,
  parameter int         BRIGHT_DEF    = 128,
  parameter int         BRIGHT_STEP   = 16,
  parameter int         NUM_FILTERS   = 4,
  parameter int         LOCKOUT_CYC   = 10000000
) (
  input logic          clk,
  input logic          rst_n,
  ir_cam_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_APPLY   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // $clog2(1) is 0 when LOCKOUT_CYC is 0, so clamp to a 1-bit counter.
  localparam int CNT_RAW = $clog2(LOCKOUT_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CNT_LD  = (LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LD);

  localparam logic [7:0] BRIGHT_RST  = 8'(BRIGHT_DEF);
  localparam logic [7:0] BRIGHT_INC  = 8'(BRIGHT_STEP);
  localparam logic [2:0] FILTER_LAST = 3'(NUM_FILTERS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       code_q;
  logic [7:0]       brightness;
  logic [2:0]       filter_mode;
  logic             freeze;
  logic             capture_req;
  logic             unknown_key;

  // Brightness arithmetic is done one bit wider so the carry/borrow shows
  // up as bit 8 and can be clamped instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? 8'h00 : s[7:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  // Key decode. Codes are meant to be distinct; if parameters collide the
  // first match in this order wins: RESET, CAPTURE, FREEZE, FILTER, UP, DN.
  logic hit_reset, hit_capture, hit_freeze, hit_filter, hit_up, hit_dn;
  logic recognised;

  always_comb begin
    hit_reset   = (code_q == KEY_RESET);
    hit_capture = !hit_reset && (code_q == KEY_CAPTURE);
    hit_freeze  = !hit_reset && !hit_capture && (code_q == KEY_FREEZE);
    hit_filter  = !hit_reset && !hit_capture && !hit_freeze
                  && (code_q == KEY_FILTER);
    hit_up      = !hit_reset && !hit_capture && !hit_freeze && !hit_filter
                  && (code_q == KEY_BRIGHT_UP);
    hit_dn      = !hit_reset && !hit_capture && !hit_freeze && !hit_filter
                  && !hit_up && (code_q == KEY_BRIGHT_DN);
    recognised  = hit_reset | hit_capture | hit_freeze | hit_filter
                  | hit_up | hit_dn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      code_q      <= 8'h00;
      brightness  <= BRIGHT_RST;
      filter_mode <= 3'd0;
      freeze      <= 1'b0;
      capture_req <= 1'b0;
      unknown_key <= 1'b0;
    end else begin
      // Pulses live for exactly one cycle unless re-asserted below.
      capture_req <= 1'b0;
      unknown_key <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.key_valid) begin
            code_q <= bus.key_code;
            state  <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          if (hit_reset) begin
            brightness  <= BRIGHT_RST;
            filter_mode <= 3'd0;
            freeze      <= 1'b0;
          end
          if (hit_capture) capture_req <= 1'b1;
          if (hit_freeze)  freeze      <= ~freeze;
          if (hit_filter)  filter_mode <= (filter_mode >= FILTER_LAST) ? 3'd0
                                          : filter_mode + 3'd1;
          if (hit_up)      brightness  <= sat_add(brightness, BRIGHT_INC);
          if (hit_dn)      brightness  <= sat_sub(brightness, BRIGHT_INC);

          if (!recognised) begin
            unknown_key <= 1'b1;
            state       <= ST_IDLE;
          end else if (LOCKOUT_CYC > 0) begin
            cnt   <= CNT_LOAD;
            state <= ST_LOCKOUT;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_LOCKOUT: begin
          // key_valid is deliberately not looked at here: presses are dropped.
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IR_CTRL_STATUS_EN
  logic [7:0] last_key;
  logic [7:0] unknown_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_key    <= 8'h00;
      unknown_cnt <= 8'h00;
    end else if (state == ST_APPLY) begin
      last_key <= code_q;
      if (!recognised) unknown_cnt <= sat_inc8(unknown_cnt);
    end
  end

  assign bus.last_key    = last_key;
  assign bus.unknown_cnt = unknown_cnt;
`endif

  assign bus.brightness  = brightness;
  assign bus.filter_mode = filter_mode;
  assign bus.freeze      = freeze;
  assign bus.capture_req = capture_req;
  assign bus.unknown_key = unknown_key;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ir_cam_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_cam_ctrl
//   Scoreboard bench for ir_cam_ctrl with LOCKOUT_CYC = 4. The stimulus
//   thread pushes one expected record per issued key; the monitor pops it
//   on the cycle after each APPLY (the negedge following the first busy
//   cycle) and also measures how long busy stayed high.
// ---------------------------------------------------------------------------
module tb_ir_cam_ctrl;

  localparam int LCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ir_cam_ctrl_if bus ();

  ir_cam_ctrl #(.LOCKOUT_CYC(LCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [2:0] f;
    logic       z;
    logic       c;
    logic       u;
    int         len;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic busy_d1 = 1'b0;
  logic busy_d2 = 1'b0;
  int   run  = 0;
  int   pend = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_d1 = 1'b0;
      busy_d2 = 1'b0;
      run     = 0;
      pend    = -1;
    end else begin
      if (busy_d1 && !busy_d2) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("brightness",  32'(bus.brightness),  32'(e.b));
          chk("filter_mode", 32'(bus.filter_mode), 32'(e.f));
          chk("freeze",      32'(bus.freeze),      32'(e.z));
          chk("capture_req", 32'(bus.capture_req), 32'(e.c));
          chk("unknown_key", 32'(bus.unknown_key), 32'(e.u));
          pend = e.len;
        end
      end else begin
        chk("idle_pulses", {30'd0, bus.capture_req, bus.unknown_key}, 32'd0);
      end
      if (bus.busy) begin
        run++;
      end else if (busy_d1) begin
        if (pend >= 0) chk("busy_len", 32'(run), 32'(pend));
        pend = -1;
        run  = 0;
      end
      busy_d2 = busy_d1;
      busy_d1 = bus.busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [7:0] code, input logic [7:0] b, input logic [2:0] f,
                      input logic z, input logic c, input logic u, input int len);
    exp_t e;
    wait_idle();
    e.b = b; e.f = f; e.z = z; e.c = c; e.u = u; e.len = len;
    q.push_back(e);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_brightness",  32'(bus.brightness),  32'd128);
    chk("rst_filter_mode", 32'(bus.filter_mode), 32'd0);
    chk("rst_freeze",      32'(bus.freeze),      32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
    chk("rst_pulses",      {30'd0, bus.capture_req, bus.unknown_key}, 32'd0);
  endtask

  logic [7:0] up_tbl [8];

  initial begin
    up_tbl = '{8'd144, 8'd160, 8'd176, 8'd192, 8'd208, 8'd224, 8'd240, 8'd255};
    bus.key_code  = 8'h00;
    bus.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();
`ifdef IR_CTRL_STATUS_EN
    chk("rst_last_key",    32'(bus.last_key),    32'd0);
    chk("rst_unknown_cnt", 32'(bus.unknown_cnt), 32'd0);
`endif

    // Brightness up to saturation, then down to zero and held there.
    for (int i = 0; i < 8; i++)
      send(8'h1A, up_tbl[i], 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);
    for (int k = 1; k <= 17; k++)
      send(8'h1E, (k < 16) ? 8'(255 - 16 * k) : 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);

    // Filter wrap; a key pressed during the lockout must be dropped.
    send(8'h12, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1 + LCK);
    @(negedge clk);
    bus.key_code  = 8'h1A;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    send(8'h12, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1 + LCK);
    send(8'h12, 8'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1 + LCK);
    send(8'h12, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);
    send(8'h12, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1 + LCK);

    // Capture pulse, then an unrecognised code.
    send(8'h0D, 8'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1 + LCK);
    send(8'h55, 8'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1);
    wait_idle();
`ifdef IR_CTRL_STATUS_EN
    chk("last_key",    32'(bus.last_key),    32'h55);
    chk("unknown_cnt", 32'(bus.unknown_cnt), 32'd1);
`endif

    // Freeze, then defaults restored by KEY_RESET.
    send(8'h16, 8'd0,   3'd1, 1'b1, 1'b0, 1'b0, 1 + LCK);
    send(8'h0C, 8'd128, 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);

    // Dirty the registers, then reset in the middle of the lockout.
    send(8'h1A, 8'd144, 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);
    send(8'h12, 8'd144, 3'd1, 1'b0, 1'b0, 1'b0, 1 + LCK);
    send(8'h16, 8'd144, 3'd1, 1'b1, 1'b0, 1'b0, 1 + LCK);
    repeat (2) @(negedge clk);
    chk("busy_in_lockout", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
`ifdef IR_CTRL_STATUS_EN
    chk("rst2_last_key",    32'(bus.last_key),    32'd0);
    chk("rst2_unknown_cnt", 32'(bus.unknown_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation resumes from defaults.
    send(8'h1A, 8'd144, 3'd0, 1'b0, 1'b0, 1'b0, 1 + LCK);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
